// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers with tick strobes, per-channel enable,
// and shadowed (apply-at-wrap) or immediate-restart divide reconfiguration.
module clk_div_bank #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2200,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_restart,
  output logic [NCH-1:0]   sclk,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             sclk_q, sclk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             hit;
    logic             wrap;

    // Channel indices are all < NCH, so an out-of-range cfg_ch never matches.
    assign hit  = cfg_wr && (cfg_ch == CH_W'(g));
    assign wrap = en[g] && (cnt_q == div_q);

    always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      sclk_d   = sclk_q;
      tick_d   = 1'b0;
      pend_d   = pend_q;
      if (hit && cfg_restart) begin
        div_d  = cfg_div;
        cnt_d  = '0;
        sclk_d = 1'b0;
        pend_d = 1'b0;
      end else begin
        if (wrap) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          tick_d = ~sclk_q;
          // A write landing on the wrap edge bypasses the shadow entirely.
          if (hit) begin
            div_d  = cfg_div;
            pend_d = 1'b0;
          end else if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
        end else if (en[g]) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (hit && !wrap) begin
          shadow_d = cfg_div;
          pend_d   = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        div_q    <= CNT_W'(DEFAULT_DIV);
        shadow_q <= '0;
        sclk_q   <= 1'b0;
        tick_q   <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        sclk_q   <= sclk_d;
        tick_q   <= tick_d;
        pend_q   <= pend_d;
      end
    end

    assign sclk[g]    = sclk_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a countdown-based reference model predicts
// {sclk,tick,pending} per cycle; a monitor compares after every clock edge.
module tb_clk_div_bank;
  // Three channels leave cfg_ch value 3 free to address a non-existent channel.
  localparam int NCH  = 3;
  localparam int CW   = 16;
  localparam int DDIV = 2200;
  localparam int CHW  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           cfg_wr = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic           cfg_restart = 1'b0;
  logic [NCH-1:0] sclk, tick, pending;

  clk_div_bank #(.NCH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_restart(cfg_restart),
    .sclk(sclk), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [3*NCH-1:0] expq[$];

  // Reference model: cycles remaining in the current half-period.
  int rem[NCH];
  int hp[NCH];
  int shadow[NCH];
  bit lvl[NCH];
  bit tk[NCH];
  bit pend[NCH];

  function automatic logic [3*NCH-1:0] model_out();
    logic [NCH-1:0] s, t, p;
    for (int i = 0; i < NCH; i++) begin
      s[i] = lvl[i]; t[i] = tk[i]; p[i] = pend[i];
    end
    return {s, t, p};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      hp[i] = DDIV + 1; rem[i] = DDIV + 1; shadow[i] = 0;
      lvl[i] = 1'b0; tk[i] = 1'b0; pend[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] e, input bit wr, input int ch,
                            input int dv, input bit rs);
    for (int i = 0; i < NCH; i++) begin
      bit hit, toggled;
      hit = wr && (ch == i);
      toggled = 1'b0;
      if (hit && rs) begin
        hp[i] = dv + 1; rem[i] = hp[i]; lvl[i] = 1'b0; tk[i] = 1'b0; pend[i] = 1'b0;
      end else begin
        tk[i] = 1'b0;
        if (e[i]) begin
          if (rem[i] == 1) begin
            toggled = 1'b1;
            lvl[i] = !lvl[i];
            tk[i] = lvl[i];
            if (hit) begin hp[i] = dv + 1; pend[i] = 1'b0; end
            else if (pend[i]) begin hp[i] = shadow[i] + 1; pend[i] = 1'b0; end
            rem[i] = hp[i];
          end else begin
            rem[i] = rem[i] - 1;
          end
        end
        if (hit && !toggled) begin shadow[i] = dv; pend[i] = 1'b1; end
      end
    end
  endtask

  task automatic step(input logic [NCH-1:0] e, input bit wr, input int ch,
                      input int dv, input bit rs);
    @(negedge clk);
    rst_n       = 1'b1;
    en          = e;
    cfg_wr      = wr;
    cfg_ch      = ch[CHW-1:0];
    cfg_div     = dv[CW-1:0];
    cfg_restart = rs;
    model_step(e, wr, ch, dv, rs);
    expq.push_back(model_out());
  endtask

  task automatic idle(input logic [NCH-1:0] e, input int n);
    for (int k = 0; k < n; k++) step(e, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    logic [3*NCH-1:0] got;
    @(negedge clk);
    #2 rst_n = 1'b0;
    cfg_wr = 1'b0;
    model_reset();
    #1 got = {sclk, tick, pending};
    nvec++;
    if (got !== model_out()) begin
      nerr++;
      $display("FAIL async_reset: got %b expected %b", got, model_out());
    end
    expq.push_back(model_out());
  endtask

  // Monitor: outputs are presented every cycle; compare 1 time unit after each edge.
  initial begin
    logic [3*NCH-1:0] exp_v, got;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp_v = expq.pop_front();
        got = {sclk, tick, pending};
        nvec++;
        if (got !== exp_v) begin
          nerr++;
          $display("FAIL cycle_out @%0t: {sclk,tick,pending} got %b expected %b",
                   $time, got, exp_v);
        end
      end
    end
  end

  localparam logic [NCH-1:0] ALL = '1;

  initial begin
    model_reset();
    do_reset();
    // Default divide: rise at edge 2201, fall at 4402.
    idle(ALL, 4410);
    // ch1 at D=0: clk/2.
    step(ALL, 1'b1, 1, 0, 1'b1);
    idle(ALL, 20);
    // ch0 at D=4, then shadow write of D=1 at cnt=2.
    step(ALL, 1'b1, 0, 4, 1'b1);
    idle(ALL, 2);
    step(ALL, 1'b1, 0, 1, 1'b0);
    idle(ALL, 20);
    // Non-restart write exactly on a ch1 wrap.
    step(ALL, 1'b1, 1, 3, 1'b1);
    idle(ALL, 5);
    for (int k = 0; k < 20 && rem[1] != 1; k++) step(ALL, 1'b0, 0, 0, 1'b0);
    step(ALL, 1'b1, 1, 6, 1'b0);
    idle(ALL, 40);
    // Hold ch2 for 7 cycles mid-half-period.
    step(ALL, 1'b1, 2, 9, 1'b1);
    idle(ALL, 4);
    idle(3'b011, 7);
    idle(ALL, 40);
    // Out-of-range writes, both flavours.
    step(ALL, 1'b1, 3, 0, 1'b1);
    step(ALL, 1'b1, 3, 5, 1'b0);
    idle(ALL, 10);
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [NCH-1:0] e;
      bit wr;
      for (int i = 0; i < NCH; i++) e[i] = ($urandom_range(0, 7) != 0);
      wr = ($urandom_range(0, 5) == 0);
      step(e, wr, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
           bit'($urandom_range(0, 1)));
    end
    // Reset mid-period with a pending shadow.
    step(ALL, 1'b1, 0, 7, 1'b1);
    idle(ALL, 3);
    step(ALL, 1'b1, 0, 2, 1'b0);
    idle(ALL, 2);
    do_reset();
    idle(ALL, 60);
    @(posedge clk);
    #2;
    nvec++;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d entries left expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
